// File: rtl/prio_encoder_arb.sv
// prio_encoder_arb: registered N-line priority arbiter with sticky pending
// bits, per-line masking, valid/ready output and fixed or round-robin modes.
module prio_encoder_arb #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending
);

  localparam int unsigned NU = N;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  if (N < 2 || N > 64) begin : g_bad_n
    $error("prio_encoder_arb: N=%0d outside 2..64", N);
  end
  if (IDX_W != $clog2(N)) begin : g_bad_idx_w
    $error("prio_encoder_arb: IDX_W=%0d must equal clog2(N)=%0d", IDX_W, $clog2(N));
  end

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [N-1:0]     clr;
  logic [N-1:0]     eligible;
  logic             hs;
  logic [IDX_W-1:0] fixed_idx;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic [IDX_W-1:0] win_idx;
  int unsigned      pos;

  assign eligible  = pending_q & ~mask;
  assign hs        = (state_q == OFFER) && out_ready;
  assign out_valid = (state_q == OFFER);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;

  // One-hot clear of the granted line on a completed handshake
  always_comb begin
    clr = '0;
    if (hs) clr[out_idx_q] = 1'b1;
  end

  // Pending update: a request in the clearing cycle wins, so none is lost
  always_comb begin
    pending_d = (pending_q & ~clr) | req_in;
  end

  // Winner selection: fixed = highest eligible index; round-robin = descending
  // scan starting just below last_idx, wrapping, so last_idx ranks lowest
  always_comb begin
    fixed_idx = '0;
    rr_idx    = '0;
    rr_found  = 1'b0;
    pos       = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (eligible[i]) fixed_idx = IDX_W'(i);
    end
    for (int unsigned k = 0; k < NU; k++) begin
      pos = 32'(last_idx_q) + NU - 1 - k;
      if (pos >= NU) pos = pos - NU;
      if (!rr_found && eligible[pos]) begin
        rr_idx   = IDX_W'(pos);
        rr_found = 1'b1;
      end
    end
    win_idx = rr_mode ? rr_idx : fixed_idx;
  end

  // Offer FSM: latch a winner in IDLE, hold it unchanged until accepted
  always_comb begin
    state_d    = state_q;
    out_idx_d  = out_idx_q;
    last_idx_d = last_idx_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          out_idx_d = win_idx;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          last_idx_d = out_idx_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      out_idx_q  <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb (N=8): scenario tasks drive stimulus and push
// expected grant indices; a monitor pops and compares on every handshake.
module tb_prio_encoder_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       rr_mode;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  prio_encoder_arb #(.N(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .rr_mode   (rr_mode),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Scoreboard: each accepted offer must match the next expected index
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got idx %0d want none", out_idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(out_idx) !== e) begin
          bad++;
          $display("FAIL grant_order: got idx %0d want %0d", out_idx, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = '0; mask = '0; rr_mode = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL reset_pending: got %h want 00", pending); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (out_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
  endtask

  task automatic test_fixed_drain();
    rr_mode = 1'b0; out_ready = 1'b1; mask = '0;
    exp_q.push_back(5); exp_q.push_back(3); exp_q.push_back(2);
    req_in = 8'h2C;
    tick();
    req_in = '0;
    total++;
    if (pending !== 8'h2C || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_latch: got pend %h valid %b want 2c 0", pending, out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (out_valid !== ((i % 2) == 0)) begin
        bad++; $display("FAIL drain_pulse%0d: got valid %b want %b", i, out_valid, (i % 2) == 0);
      end
    end
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL drain_pending: got %h want 00", pending); end
    chk_drained("drain");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req_in = 8'h20;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_in = '0;
      total++;
      if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
        bad++; $display("FAIL hold%0d: got valid %b idx %0d want 1 5", i, out_valid, out_idx);
      end
    end
    total++;
    if (pending !== 8'hA0) begin bad++; $display("FAIL hold_pending: got %h want a0", pending); end
    exp_q.push_back(5); exp_q.push_back(7);
    out_ready = 1'b1;
    tick(); tick(); tick();
    total++;
    if (pending !== 8'h00 || out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_end: got pend %h valid %b want 00 0", pending, out_valid);
    end
    chk_drained("hold");
  endtask

  task automatic test_round_robin();
    test_reset();
    rr_mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(7);
    exp_q.push_back(0); exp_q.push_back(7);
    req_in = 8'h81;
    for (int i = 0; i < 8; i++) tick();
    req_in = '0;
    tick(); tick(); tick();
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL rr_pending: got %h want 00", pending); end
    chk_drained("rr");
    rr_mode = 1'b0;
    exp_q.push_back(7); exp_q.push_back(7); exp_q.push_back(7); exp_q.push_back(0);
    req_in = 8'h81;
    for (int i = 0; i < 6; i++) tick();
    req_in = '0;
    tick(); tick(); tick();
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL fixed_held_pending: got %h want 00", pending); end
    chk_drained("fixed_held");
  endtask

  task automatic test_mask();
    rr_mode = 1'b0; out_ready = 1'b1; mask = 8'h80;
    exp_q.push_back(0); exp_q.push_back(7);
    req_in = 8'h81;
    tick();
    req_in = '0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      bad++; $display("FAIL mask_grant: got valid %b idx %0d want 1 0", out_valid, out_idx);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || pending !== 8'h80) begin
        bad++; $display("FAIL mask_block%0d: got valid %b pend %h want 0 80", i, out_valid, pending);
      end
    end
    mask = '0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      bad++; $display("FAIL unmask_grant: got valid %b idx %0d want 1 7", out_valid, out_idx);
    end
    tick();
    chk_drained("mask");
  endtask

  task automatic test_collision();
    out_ready = 1'b0;
    req_in = 8'h20;
    tick();
    req_in = '0;
    tick();
    exp_q.push_back(5); exp_q.push_back(5);
    out_ready = 1'b1;
    req_in = 8'h20;
    tick();
    req_in = '0;
    total++;
    if (pending !== 8'h20 || out_valid !== 1'b0) begin
      bad++; $display("FAIL collide_keep: got pend %h valid %b want 20 0", pending, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      bad++; $display("FAIL collide_reoffer: got valid %b idx %0d want 1 5", out_valid, out_idx);
    end
    tick();
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL collide_end: got %h want 00", pending); end
    chk_drained("collide");
  endtask

  task automatic test_async_reset();
    rr_mode = 1'b0; out_ready = 1'b0;
    req_in = 8'h08;
    tick();
    req_in = 8'h40;
    tick();
    req_in = '0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
      bad++; $display("FAIL pre_reset_offer: got valid %b idx %0d want 1 3", out_valid, out_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL async_reset: got valid %b pend %h want 0 00", out_valid, pending);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle%0d: got %b want 0", i, out_valid); end
    end
    rr_mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(0);
    req_in = 8'h09;
    tick();
    req_in = '0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
      bad++; $display("FAIL rr_first: got valid %b idx %0d want 1 3", out_valid, out_idx);
    end
    tick(); tick(); tick();
    total++;
    if (pending !== 8'h00) begin bad++; $display("FAIL rr_first_end: got %h want 00", pending); end
    chk_drained("async");
  endtask

  initial begin
    test_reset();
    test_fixed_drain();
    test_backpressure();
    test_round_robin();
    test_mask();
    test_collision();
    test_async_reset();
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_arb.md
Name: prio_encoder_arb

Overview:
- Parametrised, registered successor of the combinational 8-to-3 priority encoder.
- Latches N request lines into a sticky pending register and applies a per-line mask.
- Offers one encoded winner index at a time over a valid/ready handshake.
- Runtime-selectable arbitration mode: fixed priority (highest index wins) or round-robin. Sits between interrupt/event sources and a single consumer.

Parameters:
- N, 8, number of request lines (2..64).
- IDX_W, 3, index width; must equal ceil(log2(N)). Elaboration error otherwise.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  request pulses/levels; a bit high at a rising edge sets the matching pending bit.
- mask  input  N  1 = line not eligible for selection; its pending bit is retained.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- out_idx  output  IDX_W  encoded winner index; valid only when out_valid=1.
- out_valid  output  1  winner offered.
- out_ready  input  1  consumer accepts the offer.
- pending  output  N  current pending register (registered).

Behaviour:
- Reset (async assert, sync release):
  - pending = 0, out_valid = 0, out_idx = 0, last_idx = 0, state = IDLE.
  - Reset asserted mid-offer drops out_valid immediately and discards the offer.
- Pending update, every edge: pending <= (pending & ~clr) | req_in.
  - clr is one-hot of out_idx when out_valid & out_ready, else 0.
  - A set and clear of the same bit in the same cycle leaves the bit set; a new request is never lost.
- eligible = pending & ~mask, taken from the registered pending value.
- FSM states: IDLE (out_valid=0), OFFER (out_valid=1).
  - IDLE: if eligible != 0, out_idx <= winner(eligible) and go to OFFER; else stay IDLE.
  - OFFER, out_ready=0: hold out_idx and out_valid unchanged. No withdrawal or replacement, even if a higher-priority request arrives, the mask changes, or rr_mode changes.
  - OFFER, out_ready=1: handshake completes; clear pending[out_idx], last_idx <= out_idx, go to IDLE.
- Throughput and latency:
  - Throughput is at most one grant per 2 cycles, because IDLE is always visited after a handshake.
  - Latency: req_in sampled at edge t -> pending bit set after t -> out_valid high after edge t+1, provided the FSM is in IDLE and the line is unmasked.
- Winner, fixed mode (rr_mode=0): highest set index of eligible.
- Winner, round-robin mode (rr_mode=1):
  - Search descending from (last_idx-1) mod N, wrapping from 0 to N-1; last_idx has lowest priority.
  - After reset, last_idx=0, so the first search starts at N-1 and matches fixed mode.
- rr_mode is sampled only in IDLE; last_idx updates on every handshake in both modes.
- Masking a line whose index is being offered does not cancel the offer.
- Unused index codes (N not a power of 2) are never produced.
- out_idx is fully registered; there is no combinational path from req_in or mask to any output.

Test Plan:
- Fixed drain: N=8, rr_mode=0, out_ready=1, one-cycle req_in=8'b0010_1100 -> grants out_idx 5, 3, 2 in that order, each out_valid pulse 1 cycle with 1 idle cycle between; pending ends at 0.
- Backpressure hold: pending[5] offered, out_ready=0 for 4 cycles, req_in[7] pulsed during the hold -> out_idx stays 5, pending=8'hA0. Raise out_ready -> grant 5 then 7.
- Round-robin fairness: rr_mode=1, req_in=8'b1000_0001 held high, out_ready=1 -> grants 7, 0, 7, 0... With rr_mode=0 and the same stimulus -> 7 every grant.
- Mask: pending=8'h81, mask=8'h80 -> only grant 0; pending stays 8'h80, out_valid stays 0. Clear mask -> grant 7.
- Set/clear collision: handshake on index 5 with req_in[5]=1 in the same cycle -> pending[5] remains 1 and index 5 is offered again 2 cycles later.
- Async reset mid-offer: drive rst_n=0 between edges while out_valid=1 -> out_valid=0 and pending=0 immediately, before the next edge. After release with no requests, out_valid stays 0. A first round-robin request on lines 0 and 3 grants 3.
